// File: rtl/alu_issue_stage.sv
// Issue stage: a command FIFO feeds operand flops that drive an external ALU.
// The result is captured after one settle cycle and held until it is consumed.
module alu_issue_stage #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_a,
  input  logic [31:0]              in_b,
  input  logic [4:0]               in_op,
  input  logic [3:0]               in_tag,
  output logic [31:0]              alu_a,
  output logic [31:0]              alu_b,
  output logic [4:0]               alu_s,
  input  logic [31:0]              alu_out,
  input  logic [31:0]              alu_mulhi,
  input  logic                     alu_carry,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [31:0]              res_data,
  output logic [31:0]              res_hi,
  output logic                     res_carry,
  output logic                     res_zero,
  output logic                     res_dz,
  output logic [3:0]               res_tag,
  output logic [$clog2(DEPTH):0]   cmd_count
);

  // state | meaning
  // IDLE  | no command in the ALU; pop as soon as the FIFO holds one
  // EXEC  | operands on the ALU, result settling; captured on this edge
  // HOLD  | result presented, waiting for res_ready
  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     FULL     = (AW+1)'(DEPTH);
  localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
  localparam logic [4:0]      OP_DIV   = 5'd3;

  state_t         state;
  logic [31:0]    fifo_a   [DEPTH];
  logic [31:0]    fifo_b   [DEPTH];
  logic [4:0]     fifo_op  [DEPTH];
  logic [3:0]     fifo_tag [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [3:0]     op_tag;
  logic           push;
  logic           pop;
  logic           nonempty;
  logic           res_fire;

  assign in_ready = (cmd_count != FULL);
  assign push     = in_valid && in_ready;
  assign nonempty = (cmd_count != '0);
  assign res_fire = res_valid && res_ready;
  // Occupancy is taken before this edge's push, so a command never bypasses the FIFO.
  assign pop      = nonempty && ((state == IDLE) || ((state == HOLD) && res_fire));

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      fifo_a[wr_ptr]   <= in_a;
      fifo_b[wr_ptr]   <= in_b;
      fifo_op[wr_ptr]  <= in_op;
      fifo_tag[wr_ptr] <= in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cmd_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   cmd_count <= cmd_count + CNT_ONE;
        2'b01:   cmd_count <= cmd_count - CNT_ONE;
        default: cmd_count <= cmd_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_s     <= '0;
      op_tag    <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_hi    <= '0;
      res_carry <= 1'b0;
      res_zero  <= 1'b0;
      res_dz    <= 1'b0;
      res_tag   <= '0;
    end else begin
      if (pop) begin
        alu_a  <= fifo_a[rd_ptr];
        alu_b  <= fifo_b[rd_ptr];
        alu_s  <= fifo_op[rd_ptr];
        op_tag <= fifo_tag[rd_ptr];
      end
      case (state)
        IDLE: begin
          if (pop) state <= EXEC;
        end
        EXEC: begin
          res_data  <= alu_out;
          res_hi    <= alu_mulhi;
          res_carry <= alu_carry;
          res_zero  <= (alu_out == 32'h0);
          res_dz    <= (alu_s == OP_DIV) && (alu_b == 32'h0);
          res_tag   <= op_tag;
          res_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (res_fire) begin
            res_valid <= 1'b0;
            state     <= pop ? EXEC : IDLE;
          end
        end
        default: begin
          res_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: behavioural ALU, push-time scoreboard, vector table
// and hand sequences for back-pressure, pointer wrap, reset and throughput.
module tb_alu_issue_stage;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_a, in_b;
  logic [4:0]  in_op;
  logic [3:0]  in_tag;
  logic [31:0] alu_a, alu_b, alu_out, alu_mulhi;
  logic [4:0]  alu_s;
  logic        alu_carry;
  logic        res_valid, res_ready;
  logic [31:0] res_data, res_hi;
  logic        res_carry, res_zero, res_dz;
  logic [3:0]  res_tag;
  logic [2:0]  cmd_count;

  always #5 clk = ~clk;

  alu_issue_stage #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
    .alu_out(alu_out), .alu_mulhi(alu_mulhi), .alu_carry(alu_carry),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_hi(res_hi),
    .res_carry(res_carry), .res_zero(res_zero), .res_dz(res_dz), .res_tag(res_tag),
    .cmd_count(cmd_count)
  );

  // Returns {hi[31:0], lo[31:0], carry}. 0 add, 1 sub, 2 mul, 3 div, 4 and, 5 or, 6 xor, else pass a.
  function automatic logic [64:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] op);
    logic [32:0] s;
    logic [63:0] p;
    alu_ref = '0;
    case (op)
      5'd0: begin s = {1'b0, a} + {1'b0, b}; alu_ref = {32'h0, s[31:0], s[32]}; end
      5'd1: begin s = {1'b0, a} - {1'b0, b}; alu_ref = {32'h0, s[31:0], s[32]}; end
      5'd2: begin p = {32'h0, a} * {32'h0, b}; alu_ref = {p, 1'b0}; end
      5'd3: alu_ref = {32'h0, (b == 32'h0) ? 32'h0 : a / b, 1'b0};
      5'd4: alu_ref = {32'h0, a & b, 1'b0};
      5'd5: alu_ref = {32'h0, a | b, 1'b0};
      5'd6: alu_ref = {32'h0, a ^ b, 1'b0};
      default: alu_ref = {32'h0, a, 1'b0};
    endcase
  endfunction

  always_comb {alu_mulhi, alu_out, alu_carry} = alu_ref(alu_a, alu_b, alu_s);

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] data;
    logic [31:0] hi;
    logic        carry;
    logic        zero;
    logic        dz;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  op;
    logic [3:0]  tag;
    logic [31:0] data;
    logic [31:0] hi;
    logic        carry;
    logic        zero;
    logic        dz;
  } vec_t;

  exp_t       sb[$];
  logic [3:0] got_tags[$];
  int         hs_cyc[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Handshakes seen here complete on the following rising edge.
  always @(negedge clk) begin
    exp_t        e;
    logic [64:0] r;
    if (rst) begin
      sb.delete();
    end else begin
      if (res_valid && res_ready) begin
        got_tags.push_back(res_tag);
        hs_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected got tag=%0h want no result", res_tag);
        end else begin
          e = sb.pop_front();
          check("sb_tag", 64'(res_tag), 64'(e.tag));
          check("sb_data", 64'(res_data), 64'(e.data));
          check("sb_hi", 64'(res_hi), 64'(e.hi));
          check("sb_carry", 64'(res_carry), 64'(e.carry));
          check("sb_zero", 64'(res_zero), 64'(e.zero));
          check("sb_dz", 64'(res_dz), 64'(e.dz));
        end
      end
      if (in_valid && in_ready) begin
        r       = alu_ref(in_a, in_b, in_op);
        e.tag   = in_tag;
        e.data  = r[32:1];
        e.hi    = r[64:33];
        e.carry = r[0];
        e.zero  = (r[32:1] == 32'h0);
        e.dz    = (in_op == 5'd3) && (in_b == 32'h0);
        sb.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] op, input logic [3:0] tag);
    bit done;
    done     = 1'b0;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    in_tag   = tag;
    in_valid = 1'b1;
    for (int n = 0; n < 64 && !done; n++) begin
      done = in_ready;
      step();
    end
    in_valid = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL push_timeout got no accept want accept tag=%0h", tag);
    end
  endtask

  task automatic wait_drain(input int budget);
    bit done;
    done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      if (sb.size() == 0 && cmd_count == 3'd0 && !res_valid) done = 1'b1;
      else step();
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL drain_timeout got pending=%0d want 0", sb.size());
    end
  endtask

  initial begin
    vec_t vecs[9];
    int   quiet_hits;

    vecs[0] = '{32'hFFFF_FFFF, 32'h1,         5'd0,  4'd5, 32'h0,         32'h0, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{32'h0001_0000, 32'h0001_0000, 5'd2,  4'd6, 32'h0,         32'h1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{32'd100,       32'd0,         5'd3,  4'd7, 32'h0,         32'h0, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{32'd100,       32'd7,         5'd3,  4'd8, 32'd14,        32'h0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{32'd5,         32'd7,         5'd1,  4'd9, 32'hFFFF_FFFE, 32'h0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{32'h0F0F_0F0F, 32'hFFFF_0000, 5'd4,  4'hA, 32'h0F0F_0000, 32'h0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{32'h1234_5678, 32'h1,         5'd0,  4'hB, 32'h1234_5679, 32'h0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{32'hDEAD_BEEF, 32'h0,         5'd31, 4'hC, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{32'h0,         32'h0,         5'd6,  4'hD, 32'h0,         32'h0, 1'b0, 1'b1, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_tag = '0; res_ready = 1'b1;
    repeat (3) step();
    check("rst_res_valid", 64'(res_valid), 64'h0);
    check("rst_count", 64'(cmd_count), 64'h0);
    check("rst_in_ready", 64'(in_ready), 64'h1);
    check("rst_alu_a", 64'(alu_a), 64'h0);
    check("rst_alu_b", 64'(alu_b), 64'h0);
    check("rst_alu_s", 64'(alu_s), 64'h0);
    check("rst_res_data", 64'(res_data), 64'h0);
    check("rst_res_tag", 64'(res_tag), 64'h0);
    rst = 1'b0;
    step();

    // Single commands: res_valid must rise exactly two edges after the push edge.
    for (int i = 0; i < 9; i++) begin
      in_a = vecs[i].a; in_b = vecs[i].b; in_op = vecs[i].op; in_tag = vecs[i].tag;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      check("lat_n0", 64'(res_valid), 64'h0);
      step();
      check("lat_n1", 64'(res_valid), 64'h0);
      step();
      check("lat_n2_valid", 64'(res_valid), 64'h1);
      check("vec_data", 64'(res_data), 64'(vecs[i].data));
      check("vec_hi", 64'(res_hi), 64'(vecs[i].hi));
      check("vec_carry", 64'(res_carry), 64'(vecs[i].carry));
      check("vec_zero", 64'(res_zero), 64'(vecs[i].zero));
      check("vec_dz", 64'(res_dz), 64'(vecs[i].dz));
      check("vec_tag", 64'(res_tag), 64'(vecs[i].tag));
      step();
      check("vec_consumed", 64'(res_valid), 64'h0);
    end

    // Back-pressure: one command held in HOLD, four queued, fifth offer refused.
    got_tags.delete();
    res_ready = 1'b0;
    for (int t = 0; t < 5; t++) push_cmd(32'(t * 3), 32'd2, 5'd0, 4'(t));
    check("bp_count_full", 64'(cmd_count), 64'd4);
    check("bp_in_ready", 64'(in_ready), 64'h0);
    check("bp_hold_tag", 64'(res_tag), 64'h0);
    in_a = 32'h55; in_b = 32'h1; in_op = 5'd0; in_tag = 4'hF; in_valid = 1'b1;
    for (int n = 0; n < 3; n++) begin
      step();
      check("bp_refused_count", 64'(cmd_count), 64'd4);
      check("bp_res_stable", 64'(res_tag), 64'h0);
    end
    in_valid = 1'b0;
    res_ready = 1'b1;
    wait_drain(100);
    check("bp_delivered", 64'(got_tags.size()), 64'd5);
    for (int t = 0; t < 5 && t < got_tags.size(); t++) check("bp_order", 64'(got_tags[t]), 64'(t));

    // Push and pop on the same edge at DEPTH-1, walked around the pointers three times.
    got_tags.delete();
    res_ready = 1'b0;
    for (int t = 0; t < 4; t++) push_cmd(32'(t), 32'(t + 1), 5'd5, 4'(t));
    check("wrap_pre_count", 64'(cmd_count), 64'd3);
    check("wrap_pre_valid", 64'(res_valid), 64'h1);
    res_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      check("wrap_in_ready", 64'(in_ready), 64'h1);
      in_a = 32'(i * 17); in_b = 32'(i); in_op = 5'(i % 7); in_tag = 4'(i + 4);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      check("wrap_count_same", 64'(cmd_count), 64'd3);
      step();
      check("wrap_hold_again", 64'(res_valid), 64'h1);
    end
    wait_drain(100);
    check("wrap_delivered", 64'(got_tags.size()), 64'd16);
    for (int t = 0; t < 16 && t < got_tags.size(); t++) check("wrap_order", 64'(got_tags[t]), 64'(t));

    // Reset while holding a result with three commands queued.
    got_tags.delete();
    res_ready = 1'b0;
    for (int t = 1; t < 5; t++) push_cmd(32'd9, 32'(t), 5'd1, 4'(t));
    check("rsth_pre_count", 64'(cmd_count), 64'd3);
    check("rsth_pre_valid", 64'(res_valid), 64'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rsth_res_valid", 64'(res_valid), 64'h0);
    check("rsth_count", 64'(cmd_count), 64'h0);
    check("rsth_in_ready", 64'(in_ready), 64'h1);
    check("rsth_alu_s", 64'(alu_s), 64'h0);
    res_ready = 1'b1;
    quiet_hits = 0;
    for (int n = 0; n < 10; n++) begin
      step();
      if (res_valid) quiet_hits++;
    end
    check("rsth_no_stale", 64'(quiet_hits), 64'h0);
    check("rsth_no_tags", 64'(got_tags.size()), 64'h0);
    push_cmd(32'd40, 32'd2, 5'd0, 4'hE);
    wait_drain(50);
    check("rsth_fresh_count", 64'(got_tags.size()), 64'd1);
    if (got_tags.size() > 0) check("rsth_fresh_tag", 64'(got_tags[0]), 64'hE);

    // Sustained throughput with res_ready held high: one result every two cycles.
    hs_cyc.delete();
    for (int t = 0; t < 6; t++)
      push_cmd($urandom, $urandom_range(0, 3), 5'($urandom_range(0, 7)), 4'(t));
    wait_drain(100);
    check("tp_results", 64'(hs_cyc.size()), 64'd6);
    for (int i = 1; i < 6 && i < hs_cyc.size(); i++)
      check("tp_gap", 64'(hs_cyc[i] - hs_cyc[i-1]), 64'd2);

    check("sb_leftover", 64'(sb.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule
